// File: rtl/forward_hazard_unit.sv
// EX-stage operand forwarding selects and load-use stall/bubble control for a
// 5-stage MIPS pipeline, driven from a private shadow of the ID/EX, EX/MEM and MEM/WB fields.
module forward_hazard_unit #(
   parameter int REG_BITS = 5,
   parameter int CNT_BITS = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                id_valid,
   input  logic [REG_BITS-1:0] id_rs,
   input  logic [REG_BITS-1:0] id_rt,
   input  logic [REG_BITS-1:0] id_dest,
   input  logic                id_regwrite,
   input  logic                id_memread,
   input  logic                flush,
   output logic [1:0]          fwd_a,
   output logic [1:0]          fwd_b,
   output logic                stall,
   output logic                bubble,
   output logic [CNT_BITS-1:0] stall_count
);

   localparam logic [1:0] SEL_RF  = 2'd0;
   localparam logic [1:0] SEL_MEM = 2'd1;
   localparam logic [1:0] SEL_WB  = 2'd2;
   localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

   // ID/EX shadow
   logic [REG_BITS-1:0] ex_rs_q, ex_rs_d;
   logic [REG_BITS-1:0] ex_rt_q, ex_rt_d;
   logic [REG_BITS-1:0] ex_dest_q, ex_dest_d;
   logic                ex_rw_q, ex_rw_d;
   logic                ex_mr_q, ex_mr_d;
   // EX/MEM and MEM/WB shadow
   logic [REG_BITS-1:0] mem_dest_q;
   logic                mem_rw_q;
   logic [REG_BITS-1:0] wb_dest_q;
   logic                wb_rw_q;
   logic [CNT_BITS-1:0] stall_count_q, stall_count_d;

   // EX/MEM has priority over MEM/WB; register 0 is never a forwarding source.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_BITS-1:0] src,
      input logic [REG_BITS-1:0] m_dest,
      input logic                m_rw,
      input logic [REG_BITS-1:0] w_dest,
      input logic                w_rw
   );
      logic [1:0] sel;
      sel = SEL_RF;
      if (m_rw && (m_dest != '0) && (m_dest == src)) begin
         sel = SEL_MEM;
      end else if (w_rw && (w_dest != '0) && (w_dest == src)) begin
         sel = SEL_WB;
      end
      return sel;
   endfunction

   always_comb begin
      fwd_a = fwd_sel(ex_rs_q, mem_dest_q, mem_rw_q, wb_dest_q, wb_rw_q);
      fwd_b = fwd_sel(ex_rt_q, mem_dest_q, mem_rw_q, wb_dest_q, wb_rw_q);
   end

   // Both ID sources are compared even if the instruction ignores rt.
   always_comb begin
      stall  = id_valid & ex_mr_q & ex_rw_q & (ex_dest_q != '0) &
               ((ex_dest_q == id_rs) | (ex_dest_q == id_rt)) & ~flush;
      bubble = stall | flush | ~id_valid;
   end

   always_comb begin
      ex_rs_d   = id_rs;
      ex_rt_d   = id_rt;
      ex_dest_d = id_dest;
      ex_rw_d   = id_regwrite;
      ex_mr_d   = id_memread;
      if (bubble) begin
         ex_rs_d   = '0;
         ex_rt_d   = '0;
         ex_dest_d = '0;
         ex_rw_d   = 1'b0;
         ex_mr_d   = 1'b0;
      end
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != '1)) begin
         stall_count_d = stall_count_q + CNT_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         ex_rs_q       <= '0;
         ex_rt_q       <= '0;
         ex_dest_q     <= '0;
         ex_rw_q       <= 1'b0;
         ex_mr_q       <= 1'b0;
         mem_dest_q    <= '0;
         mem_rw_q      <= 1'b0;
         wb_dest_q     <= '0;
         wb_rw_q       <= 1'b0;
         stall_count_q <= '0;
      end else begin
         ex_rs_q       <= ex_rs_d;
         ex_rt_q       <= ex_rt_d;
         ex_dest_q     <= ex_dest_d;
         ex_rw_q       <= ex_rw_d;
         ex_mr_q       <= ex_mr_d;
         mem_dest_q    <= ex_dest_q;
         mem_rw_q      <= ex_rw_q;
         wb_dest_q     <= mem_dest_q;
         wb_rw_q       <= mem_rw_q;
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;

endmodule
